// File: rtl/vowel_classifier_pkg.sv
// Shared constants, state encoding and result-entry layout for vowel_classifier.
package vowel_classifier_pkg;

    localparam int DEF_NUM_CLASSES = 3;
    localparam int DEF_WIDTH       = 8;
    localparam int DEF_FRAC_BITS   = 5;

    localparam int CLASS_W  = 2;
    localparam int MARGIN_W = 8;
    localparam int COUNT_W  = 8;

    // Q3.5 reference levels
    localparam int Q_ONE       = 32;
    localparam int Q_MINUS_ONE = -32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_PUSH = 2'd2
    } state_e;

    // Entry layout, MSB first: {class, code, margin, unknown}
    function automatic int entry_w(input int num_classes);
        return CLASS_W + num_classes + MARGIN_W + 1;
    endfunction

endpackage

// File: rtl/vowel_classifier_result_fifo.sv
// Synchronous result FIFO; a push into a full FIFO is accepted only alongside a pop.
module result_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/vowel_classifier.sv
// Sequential argmax/runner-up classifier over signed network outputs, results queued in a FIFO.
//   state | meaning
//   IDLE  | waiting for VALID_IN, vector latched on acceptance
//   SCAN  | one channel per cycle through the single comparator
//   PUSH  | result entry written to the FIFO (dropped if full without pop)
module vowel_classifier
    import vowel_classifier_pkg::*;
#(
    parameter int NUM_CLASSES = DEF_NUM_CLASSES,
    parameter int WIDTH       = DEF_WIDTH,
    parameter int FRAC_BITS   = DEF_FRAC_BITS,
    parameter int MARGIN_TH   = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                         CLK,
    input  logic                         RSTN,
    input  logic [NUM_CLASSES*WIDTH-1:0] VALUES_IN,
    input  logic                         VALID_IN,
    output logic [CLASS_W-1:0]           CLASS_OUT,
    output logic [NUM_CLASSES-1:0]       CODE_OUT,
    output logic [MARGIN_W-1:0]          MARGIN_OUT,
    output logic                         UNKNOWN_OUT,
    output logic                         VALID_OUT,
    input  logic                         READY_IN,
    input  logic                         CLEAR_IN,
    output logic                         OVERRUN_OUT,
    output logic [COUNT_W-1:0]           DROP_COUNT
);

    localparam int ENTRY_W = entry_w(NUM_CLASSES);
    localparam logic [MARGIN_W-1:0] MARGIN_TH_L = MARGIN_W'(MARGIN_TH);
    localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    if (FRAC_BITS >= WIDTH || NUM_CLASSES < 2 || NUM_CLASSES > 4) begin : g_bad_params
        $error("vowel_classifier: unsupported parameter combination");
    end

    state_e                       state_q, state_d;
    logic [CLASS_W-1:0]           idx_q, idx_d;
    logic [CLASS_W-1:0]           best_idx_q, best_idx_d;
    logic [NUM_CLASSES*WIDTH-1:0] vals_q, vals_d;
    logic signed [WIDTH-1:0]      best_q, best_d;
    logic signed [WIDTH-1:0]      second_q, second_d;
    logic                         overrun_q, overrun_d;
    logic [COUNT_W-1:0]           drop_cnt_q, drop_cnt_d;

    logic signed [WIDTH-1:0]      cur;
    logic [NUM_CLASSES-1:0]       code;
    logic signed [WIDTH:0]        diff;
    logic [MARGIN_W-1:0]          margin;
    logic                         unknown;
    logic                         push, pop, full, empty;
    logic                         drop_in, drop_push;
    logic [1:0]                   drops;
    logic [COUNT_W:0]             cnt_sum;
    logic [ENTRY_W-1:0]           push_data, head;

    always_comb begin
        cur = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (idx_q == CLASS_W'(i)) begin
                cur = vals_q[i*WIDTH +: WIDTH];
            end
            code[i] = ~vals_q[i*WIDTH + WIDTH - 1];
        end
    end

    // best >= second always holds, so the 9-bit difference lies in 0..255
    assign diff      = (WIDTH+1)'(best_q) - (WIDTH+1)'(second_q);
    assign margin    = MARGIN_W'(diff);
    assign unknown   = (margin < MARGIN_TH_L) || best_q[WIDTH-1];
    assign push_data = {best_idx_q, code, margin, unknown};

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        vals_d     = vals_q;
        best_d     = best_q;
        second_d   = second_q;
        best_idx_d = best_idx_q;
        push       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (VALID_IN) begin
                    vals_d     = VALUES_IN;
                    idx_d      = '0;
                    best_d     = MIN_VAL;
                    second_d   = MIN_VAL;
                    best_idx_d = '0;
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (cur > best_q) begin
                    second_d   = best_q;
                    best_d     = cur;
                    best_idx_d = idx_q;
                end else if (cur > second_q) begin
                    second_d = cur;
                end
                if (idx_q == CLASS_W'(NUM_CLASSES - 1)) begin
                    state_d = ST_PUSH;
                end else begin
                    idx_d = idx_q + CLASS_W'(1);
                end
            end
            ST_PUSH: begin
                push    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pop       = !empty && READY_IN;
    assign drop_in   = VALID_IN && (state_q != ST_IDLE);
    assign drop_push = push && full && !pop;
    assign drops     = {1'b0, drop_in} + {1'b0, drop_push};
    assign cnt_sum   = {1'b0, drop_cnt_q} + (COUNT_W+1)'(drops);

    always_comb begin
        overrun_d  = overrun_q;
        drop_cnt_d = drop_cnt_q;
        if (CLEAR_IN) begin
            overrun_d  = 1'b0;
            drop_cnt_d = '0;
        end else if (drops != 2'd0) begin
            overrun_d  = 1'b1;
            drop_cnt_d = cnt_sum[COUNT_W] ? '1 : cnt_sum[COUNT_W-1:0];
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            vals_q     <= '0;
            best_q     <= '0;
            second_q   <= '0;
            best_idx_q <= '0;
            overrun_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            vals_q     <= vals_d;
            best_q     <= best_d;
            second_q   <= second_d;
            best_idx_q <= best_idx_d;
            overrun_q  <= overrun_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    result_fifo #(
        .DW    (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RSTN),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign VALID_OUT   = !empty;
    assign CLASS_OUT   = head[ENTRY_W-1 -: CLASS_W];
    assign CODE_OUT    = head[MARGIN_W+1 +: NUM_CLASSES];
    assign MARGIN_OUT  = head[1 +: MARGIN_W];
    assign UNKNOWN_OUT = head[0];
    assign OVERRUN_OUT = overrun_q;
    assign DROP_COUNT  = drop_cnt_q;

endmodule

// File: tb/tb_vowel_classifier.sv
// Scoreboard bench for vowel_classifier: directed vectors, overrun/drop, reset abort, saturation.
module tb_vowel_classifier;
    import vowel_classifier_pkg::*;

    localparam int NC = 3;
    localparam int W  = 8;

    logic            CLK = 1'b0;
    logic            RSTN = 1'b0;
    logic [NC*W-1:0] VALUES_IN = '0;
    logic            VALID_IN = 1'b0;
    logic [1:0]      CLASS_OUT;
    logic [NC-1:0]   CODE_OUT;
    logic [7:0]      MARGIN_OUT;
    logic            UNKNOWN_OUT;
    logic            VALID_OUT;
    logic            READY_IN = 1'b0;
    logic            CLEAR_IN = 1'b0;
    logic            OVERRUN_OUT;
    logic [7:0]      DROP_COUNT;

    vowel_classifier dut (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .VALUES_IN   (VALUES_IN),
        .VALID_IN    (VALID_IN),
        .CLASS_OUT   (CLASS_OUT),
        .CODE_OUT    (CODE_OUT),
        .MARGIN_OUT  (MARGIN_OUT),
        .UNKNOWN_OUT (UNKNOWN_OUT),
        .VALID_OUT   (VALID_OUT),
        .READY_IN    (READY_IN),
        .CLEAR_IN    (CLEAR_IN),
        .OVERRUN_OUT (OVERRUN_OUT),
        .DROP_COUNT  (DROP_COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0] cls;
        logic [2:0] code;
        logic [7:0] margin;
        logic       unk;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    endtask

    function automatic exp_t mk(input int cls, input int code, input int m, input int u);
        return {2'(cls), 3'(code), 8'(m), 1'(u)};
    endfunction

    exp_t got;
    always @(negedge CLK) begin
        if (RSTN && VALID_OUT && READY_IN) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_result: got class %0d margin %0d, expected no result",
                         CLASS_OUT, MARGIN_OUT);
            end else begin
                got = {CLASS_OUT, CODE_OUT, MARGIN_OUT, UNKNOWN_OUT};
                chk("result", 32'(got), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic set_vals(input int v0, input int v1, input int v2);
        VALUES_IN = {W'(v2), W'(v1), W'(v0)};
    endtask

    task automatic drive(input int v0, input int v1, input int v2);
        set_vals(v0, v1, v2);
        VALID_IN = 1'b1;
        cycles(1);
        VALID_IN = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge CLK);
        #1;
        chk("drain_remaining", 32'(exp_q.size()), 0);
    endtask

    task automatic run_vec(input int v0, input int v1, input int v2, input exp_t e);
        exp_q.push_back(e);
        drive(v0, v1, v2);
        wait_drain();
        cycles(2);
    endtask

    task automatic latency_vec(input int v0, input int v1, input int v2, input exp_t e);
        exp_q.push_back(e);
        drive(v0, v1, v2);
        cycles(3);
        chk("valid_before_t5", 32'(VALID_OUT), 0);
        cycles(1);
        chk("valid_at_t5", 32'(VALID_OUT), 1);
        chk("class_at_t5", 32'(CLASS_OUT), 32'(e.cls));
        wait_drain();
        cycles(2);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"},   32'(VALID_OUT),   0);
        chk({tag, "_class"},   32'(CLASS_OUT),   0);
        chk({tag, "_code"},    32'(CODE_OUT),    0);
        chk({tag, "_margin"},  32'(MARGIN_OUT),  0);
        chk({tag, "_unknown"}, 32'(UNKNOWN_OUT), 0);
        chk({tag, "_overrun"}, 32'(OVERRUN_OUT), 0);
        chk({tag, "_drops"},   32'(DROP_COUNT),  0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cycles(3);
        chk_all_zero("reset");
        RSTN = 1'b1;
        cycles(2);
        READY_IN = 1'b1;

        latency_vec(Q_MINUS_ONE, Q_ONE, Q_MINUS_ONE, mk(1, 3'b010, 64, 0));
        run_vec(16, 16, -32,    mk(0, 3'b011, 0, 1));
        run_vec(127, -128, -128, mk(0, 3'b001, 255, 0));
        run_vec(-10, -10, -10,  mk(0, 3'b000, 0, 1));
        run_vec(16, 0, -5,      mk(0, 3'b011, 16, 0));
        run_vec(15, 0, -5,      mk(0, 3'b011, 15, 1));
        run_vec(-1, -2, 20,     mk(2, 3'b100, 21, 0));

        // FIFO full with consumer stalled: fifth result is dropped
        READY_IN = 1'b0;
        exp_q.push_back(mk(0, 3'b111, 32, 0));
        exp_q.push_back(mk(1, 3'b111, 32, 0));
        exp_q.push_back(mk(2, 3'b111, 32, 0));
        exp_q.push_back(mk(1, 3'b010, 64, 0));
        drive(32, 0, 0);   cycles(5);
        drive(0, 32, 0);   cycles(5);
        drive(0, 0, 32);   cycles(5);
        drive(-32, 32, -32); cycles(5);
        drive(10, 20, 30); cycles(5);
        chk("full_drops", 32'(DROP_COUNT), 1);
        chk("full_overrun", 32'(OVERRUN_OUT), 1);
        chk("full_valid", 32'(VALID_OUT), 1);
        cycles(3);
        chk("stall_class", 32'(CLASS_OUT), 0);
        chk("stall_margin", 32'(MARGIN_OUT), 32);
        READY_IN = 1'b1;
        wait_drain();
        CLEAR_IN = 1'b1;
        cycles(1);
        CLEAR_IN = 1'b0;
        chk("clear_drops", 32'(DROP_COUNT), 0);
        chk("clear_overrun", 32'(OVERRUN_OUT), 0);

        // second VALID_IN two cycles later lands in SCAN
        exp_q.push_back(mk(2, 3'b101, 32, 0));
        set_vals(0, -32, 32);
        VALID_IN = 1'b1;
        cycles(1);
        VALID_IN = 1'b0;
        cycles(1);
        set_vals(99, 0, 0);
        VALID_IN = 1'b1;
        cycles(1);
        VALID_IN = 1'b0;
        wait_drain();
        cycles(10);
        chk("busy_drops", 32'(DROP_COUNT), 1);
        chk("busy_overrun", 32'(OVERRUN_OUT), 1);

        // reset in the middle of SCAN aborts the vector
        drive(50, 0, 0);
        cycles(1);
        RSTN = 1'b0;
        #1;
        chk_all_zero("midreset");
        cycles(2);
        RSTN = 1'b1;
        cycles(8);
        chk("post_reset_valid", 32'(VALID_OUT), 0);
        latency_vec(Q_MINUS_ONE, Q_MINUS_ONE, Q_ONE, mk(2, 3'b100, 64, 0));

        // VALID_IN held high: accepted every 5th cycle, the rest counted as drops
        for (int i = 0; i < 80; i++) exp_q.push_back(mk(2, 3'b101, 35, 0));
        set_vals(5, -3, 40);
        VALID_IN = 1'b1;
        cycles(400);
        VALID_IN = 1'b0;
        chk("sat_drops", 32'(DROP_COUNT), 255);
        chk("sat_overrun", 32'(OVERRUN_OUT), 1);
        wait_drain();

        // clear wins over a simultaneous drop
        exp_q.push_back(mk(2, 3'b111, 1, 1));
        drive(1, 2, 3);
        VALID_IN = 1'b1;
        CLEAR_IN = 1'b1;
        cycles(1);
        VALID_IN = 1'b0;
        CLEAR_IN = 1'b0;
        chk("clear_prio_drops", 32'(DROP_COUNT), 0);
        chk("clear_prio_overrun", 32'(OVERRUN_OUT), 0);
        wait_drain();
        cycles(5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
